axis_processor_arbiter: RTL and testbench
=========================================

Name: axis_processor_arbiter

Overview:
- Shares one axis_processor_tlast instance between two AXI-Stream requesters.
- Arbitrates round-robin at packet granularity on the input side and forwards the granted requester's packet unbroken to the processor input.
- Records the grant order and routes each processor output packet back to the requester whose input packet produced it.
- Sits between host DMA channels and the processor core.

Parameters:
- INP_TDATA_WIDTH_BYTES, 4, byte width of requester and processor input tdata.
- OUT_TDATA_WIDTH_BYTES, 4, byte width of processor and response output tdata.
- ORDER_DEPTH, 4, number of outstanding packets tracked in the order FIFO; power of 2, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
- s0_tvalid/s0_tready/s0_tlast  in/out/in  1 each  requester 0 input stream control.
- s0_tdata  in  INP_TDATA_WIDTH_BYTES*8  requester 0 data.
- s0_tkeep  in  INP_TDATA_WIDTH_BYTES  requester 0 keep.
- s1_tvalid/s1_tready/s1_tlast/s1_tdata/s1_tkeep  same as s0_*, requester 1.
- p_s_tvalid/p_s_tready/p_s_tlast  out/in/out  1 each  processor input stream control.
- p_s_tdata  out  INP_TDATA_WIDTH_BYTES*8  processor input data.
- p_s_tkeep  out  INP_TDATA_WIDTH_BYTES  processor input keep.
- p_m_tvalid/p_m_tready/p_m_tlast  in/out/in  1 each  processor output stream control.
- p_m_tdata  in  OUT_TDATA_WIDTH_BYTES*8  processor output data.
- p_m_tkeep  in  OUT_TDATA_WIDTH_BYTES  processor output keep.
- m0_tvalid/m0_tready/m0_tlast  out/in/out  1 each  response stream to requester 0.
- m0_tdata  out  OUT_TDATA_WIDTH_BYTES*8  response data to requester 0.
- m0_tkeep  out  OUT_TDATA_WIDTH_BYTES  response keep to requester 0.
- m1_*  same as m0_*, requester 1.
- busy  out  1  high when in a GRANT state or the order FIFO is non-empty.

Behaviour:
- Reset (arstn low, asynchronous): state IDLE, priority pointer = 0, order FIFO empty.
  - All tvalid/tready outputs 0 and busy 0.
  - Data, keep and last outputs 0.
  - Reset mid-packet truncates the packet; no recovery is attempted.
- Input FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: all s*_tready = 0 and p_s_tvalid = 0.
  - IDLE: if the FIFO is not full and any s*_tvalid is high, enter GRANTx at the next edge.
  - IDLE: when both requesters are valid, the requester equal to the pointer wins; when one is valid, it wins.
  - GRANTx: combinational pass-through, zero added latency.
    - p_s_tvalid = sx_tvalid; sx_tready = p_s_tready.
    - p_s_tdata/tkeep/tlast = sx_*.
    - Non-granted s*_tready = 0.
  - GRANTx exit: on the handshake of sx_tlast, push x into the order FIFO, set pointer = ~x and return to IDLE.
- Arbitration timing:
  - Minimum 1 idle cycle between packets.
  - First-beat latency is 1 cycle from IDLE.
  - The order FIFO is never pushed while full: the full check happens in IDLE, and a grant reserves a slot.
- Response path:
  - FIFO head h selects the destination.
  - p_m_tready = mh_tready; mh_tvalid = p_m_tvalid.
  - mh_tdata/tkeep/tlast = p_m_*.
  - The other m*_tvalid = 0.
- FIFO empty: p_m_tready = 0 and both m*_tvalid = 0. Output beats stall; they are not dropped.
- Pop the FIFO on the handshake of p_m_tlast.
- Simultaneous push and pop in the same cycle are both honoured; the count is unchanged.
- FIFO pointers are log2(ORDER_DEPTH)+1 bits wide; wrap is modulo 2*ORDER_DEPTH.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
- A valid requester is never starved beyond one packet of the other requester.

Optional Feature:
- Macro: ARB_PKT_COUNT_EN.
- When defined, add outputs pkt_cnt0 and pkt_cnt1, 16 bits each.
  - These count completed input packets per requester; each increments on that requester's tlast handshake.
  - Counts saturate at 16'hFFFF.
  - Both clear on reset.
- When undefined, the ports and logic are absent.

Test Plan:
- Single packet from s0: beats 8'h08, 8'h20, 8'h28 (last), tkeep 4'b1111, p_s_tready=1.
  - Response: p_s_* carries 3 beats starting 1 cycle after s0_tvalid.
  - Response: the processor response appears only on m0_* and m1_tvalid stays 0.
- Both requesters continuously valid, 2-beat packets:
  - Grants alternate s0, s1, s0, s1 with exactly 1 idle cycle between packets.
  - Responses return in grant order to m0 and m1.
- Order FIFO full (ORDER_DEPTH=4, p_m_tvalid held 0):
  - After 4 packets, s*_tready stays 0 and the FSM stays IDLE.
  - One response packet drained triggers a new grant on the next cycle.
- Backpressure: toggle p_s_tready and m0_tready every cycle.
  - No beat lost or duplicated; tlast stays aligned; data matches beat for beat.
- Reset asserted mid-packet (beat 2 of 3):
  - All outputs go 0 immediately.
  - After release, a fresh s1 packet is granted normally with the pointer at 0 precedence.
- With ARB_PKT_COUNT_EN defined: 3 s0 packets and 2 s1 packets give pkt_cnt0=3 and pkt_cnt1=2.

Source files
------------

// File: rtl/axis_processor_arbiter.sv
// Round-robin packet arbiter sharing one stream processor between two requesters,
// routing responses back by grant order. Optional per-requester packet counters: ARB_PKT_COUNT_EN.
module axis_processor_arbiter #(
    parameter int INP_TDATA_WIDTH_BYTES = 4,
    parameter int OUT_TDATA_WIDTH_BYTES = 4,
    parameter int ORDER_DEPTH           = 4
) (
    input  logic                                 clk,
    input  logic                                 arstn,
    input  logic                                 s0_tvalid,
    output logic                                 s0_tready,
    input  logic                                 s0_tlast,
    input  logic [INP_TDATA_WIDTH_BYTES*8-1:0]   s0_tdata,
    input  logic [INP_TDATA_WIDTH_BYTES-1:0]     s0_tkeep,
    input  logic                                 s1_tvalid,
    output logic                                 s1_tready,
    input  logic                                 s1_tlast,
    input  logic [INP_TDATA_WIDTH_BYTES*8-1:0]   s1_tdata,
    input  logic [INP_TDATA_WIDTH_BYTES-1:0]     s1_tkeep,
    output logic                                 p_s_tvalid,
    input  logic                                 p_s_tready,
    output logic                                 p_s_tlast,
    output logic [INP_TDATA_WIDTH_BYTES*8-1:0]   p_s_tdata,
    output logic [INP_TDATA_WIDTH_BYTES-1:0]     p_s_tkeep,
    input  logic                                 p_m_tvalid,
    output logic                                 p_m_tready,
    input  logic                                 p_m_tlast,
    input  logic [OUT_TDATA_WIDTH_BYTES*8-1:0]   p_m_tdata,
    input  logic [OUT_TDATA_WIDTH_BYTES-1:0]     p_m_tkeep,
    output logic                                 m0_tvalid,
    input  logic                                 m0_tready,
    output logic                                 m0_tlast,
    output logic [OUT_TDATA_WIDTH_BYTES*8-1:0]   m0_tdata,
    output logic [OUT_TDATA_WIDTH_BYTES-1:0]     m0_tkeep,
    output logic                                 m1_tvalid,
    input  logic                                 m1_tready,
    output logic                                 m1_tlast,
    output logic [OUT_TDATA_WIDTH_BYTES*8-1:0]   m1_tdata,
    output logic [OUT_TDATA_WIDTH_BYTES-1:0]     m1_tkeep,
    output logic                                 busy
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [15:0]                          pkt_cnt0,
    output logic [15:0]                          pkt_cnt1
`endif
);

    localparam int AW = $clog2(ORDER_DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 state;
    logic                   ptr;
    logic [ORDER_DEPTH-1:0] order_mem;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   full;
    logic                   empty;
    logic                   head;
    logic                   push;
    logic                   push_id;
    logic                   pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign head    = order_mem[rd_ptr[AW-1:0]];
    assign push_id = (state == GRANT1);
    assign push    = ((state == GRANT0) && s0_tvalid && p_s_tready && s0_tlast) ||
                     ((state == GRANT1) && s1_tvalid && p_s_tready && s1_tlast);
    assign pop     = !empty && p_m_tvalid && p_m_tready && p_m_tlast;
    assign busy    = (state != IDLE) || !empty;

    // The full check lives only in IDLE; a grant in flight owns the last free slot.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            order_mem <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!full) begin
                        if (s0_tvalid && s1_tvalid)
                            state <= ptr ? GRANT1 : GRANT0;
                        else if (s0_tvalid)
                            state <= GRANT0;
                        else if (s1_tvalid)
                            state <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (push) begin
                        state <= IDLE;
                        ptr   <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (push) begin
                        state <= IDLE;
                        ptr   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                order_mem[wr_ptr[AW-1:0]] <= push_id;
                wr_ptr                    <= wr_ptr + (AW+1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_comb begin
        p_s_tvalid = 1'b0;
        p_s_tlast  = 1'b0;
        p_s_tdata  = '0;
        p_s_tkeep  = '0;
        s0_tready  = 1'b0;
        s1_tready  = 1'b0;
        case (state)
            GRANT0: begin
                p_s_tvalid = s0_tvalid;
                p_s_tlast  = s0_tlast;
                p_s_tdata  = s0_tdata;
                p_s_tkeep  = s0_tkeep;
                s0_tready  = p_s_tready;
            end
            GRANT1: begin
                p_s_tvalid = s1_tvalid;
                p_s_tlast  = s1_tlast;
                p_s_tdata  = s1_tdata;
                p_s_tkeep  = s1_tkeep;
                s1_tready  = p_s_tready;
            end
            default: ;
        endcase
    end

    // Response beats stall while no destination is known.
    always_comb begin
        p_m_tready = 1'b0;
        m0_tvalid  = 1'b0;
        m0_tlast   = 1'b0;
        m0_tdata   = '0;
        m0_tkeep   = '0;
        m1_tvalid  = 1'b0;
        m1_tlast   = 1'b0;
        m1_tdata   = '0;
        m1_tkeep   = '0;
        if (!empty) begin
            if (!head) begin
                p_m_tready = m0_tready;
                m0_tvalid  = p_m_tvalid;
                m0_tlast   = p_m_tlast;
                m0_tdata   = p_m_tdata;
                m0_tkeep   = p_m_tkeep;
            end else begin
                p_m_tready = m1_tready;
                m1_tvalid  = p_m_tvalid;
                m1_tlast   = p_m_tlast;
                m1_tdata   = p_m_tdata;
                m1_tkeep   = p_m_tkeep;
            end
        end
    end

`ifdef ARB_PKT_COUNT_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (push) begin
            if (!push_id && (pkt_cnt0 != '1))
                pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (push_id && (pkt_cnt1 != '1))
                pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Directed self-checking bench for axis_processor_arbiter (default parameters).
module tb_axis_processor_arbiter;

    logic        clk;
    logic        arstn;
    logic        s0_tvalid, s0_tready, s0_tlast;
    logic [31:0] s0_tdata;
    logic [3:0]  s0_tkeep;
    logic        s1_tvalid, s1_tready, s1_tlast;
    logic [31:0] s1_tdata;
    logic [3:0]  s1_tkeep;
    logic        p_s_tvalid, p_s_tready, p_s_tlast;
    logic [31:0] p_s_tdata;
    logic [3:0]  p_s_tkeep;
    logic        p_m_tvalid, p_m_tready, p_m_tlast;
    logic [31:0] p_m_tdata;
    logic [3:0]  p_m_tkeep;
    logic        m0_tvalid, m0_tready, m0_tlast;
    logic [31:0] m0_tdata;
    logic [3:0]  m0_tkeep;
    logic        m1_tvalid, m1_tready, m1_tlast;
    logic [31:0] m1_tdata;
    logic [3:0]  m1_tkeep;
    logic        busy;
`ifdef ARB_PKT_COUNT_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    int checks;
    int failures;

    axis_processor_arbiter #(
        .INP_TDATA_WIDTH_BYTES(4),
        .OUT_TDATA_WIDTH_BYTES(4),
        .ORDER_DEPTH(4)
    ) dut (
        .clk(clk), .arstn(arstn),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
        .p_s_tvalid(p_s_tvalid), .p_s_tready(p_s_tready), .p_s_tlast(p_s_tlast),
        .p_s_tdata(p_s_tdata), .p_s_tkeep(p_s_tkeep),
        .p_m_tvalid(p_m_tvalid), .p_m_tready(p_m_tready), .p_m_tlast(p_m_tlast),
        .p_m_tdata(p_m_tdata), .p_m_tkeep(p_m_tkeep),
        .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast),
        .m0_tdata(m0_tdata), .m0_tkeep(m0_tkeep),
        .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast),
        .m1_tdata(m1_tdata), .m1_tkeep(m1_tkeep),
        .busy(busy)
`ifdef ARB_PKT_COUNT_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        s0_tvalid = 0; s1_tvalid = 0; p_m_tvalid = 0;
        @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        tick();
    endtask

    // One single-beat packet from requester x, then its single-beat response.
    task automatic one_pkt(input int x, input logic [31:0] d);
        p_s_tready = 1; m0_tready = 1; m1_tready = 1;
        if (x == 0) begin s0_tvalid = 1; s0_tdata = d; s0_tlast = 1; end
        else        begin s1_tvalid = 1; s1_tdata = d; s1_tlast = 1; end
        #1;
        check("pk_idle", p_s_tvalid, 0);
        tick();
        check("pk_data", p_s_tdata, d);
        check("pk_ready", (x == 0) ? s0_tready : s1_tready, 1);
        tick();
        s0_tvalid = 0; s1_tvalid = 0;
        p_m_tvalid = 1; p_m_tdata = ~d; p_m_tlast = 1; p_m_tkeep = 4'hF;
        #1;
        check("pk_rsp_valid", (x == 0) ? m0_tvalid : m1_tvalid, 1);
        check("pk_rsp_other", (x == 0) ? m1_tvalid : m0_tvalid, 0);
        check("pk_rsp_data", (x == 0) ? m0_tdata : m1_tdata, ~d);
        tick();
        p_m_tvalid = 0;
    endtask

    initial begin
        int beat;
        int x;
        checks = 0; failures = 0;
        arstn = 0;
        s0_tvalid = 0; s0_tlast = 0; s0_tdata = 0; s0_tkeep = 4'hF;
        s1_tvalid = 0; s1_tlast = 0; s1_tdata = 0; s1_tkeep = 4'hF;
        p_s_tready = 0; p_m_tvalid = 0; p_m_tlast = 0; p_m_tdata = 0; p_m_tkeep = 0;
        m0_tready = 0; m1_tready = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_p_s_tvalid", p_s_tvalid, 0);
        check("rst_s0_tready", s0_tready, 0);
        check("rst_s1_tready", s1_tready, 0);
        check("rst_m0_tvalid", m0_tvalid, 0);
        check("rst_m1_tvalid", m1_tvalid, 0);
        check("rst_p_m_tready", p_m_tready, 0);
        check("rst_p_s_tdata", p_s_tdata, 0);
        @(negedge clk);
        arstn = 1;
        tick();

        // Single 3-beat packet from s0
        p_s_tready = 1; s0_tvalid = 1; s0_tdata = 32'h08; s0_tlast = 0;
        #1;
        check("t1_idle", p_s_tvalid, 0);
        tick();
        check("t1_b0_valid", p_s_tvalid, 1);
        check("t1_b0_data", p_s_tdata, 32'h08);
        check("t1_b0_keep", p_s_tkeep, 4'hF);
        check("t1_s0_ready", s0_tready, 1);
        check("t1_s1_ready", s1_tready, 0);
        check("t1_busy", busy, 1);
        tick();
        s0_tdata = 32'h20; #1;
        check("t1_b1_data", p_s_tdata, 32'h20);
        check("t1_b1_last", p_s_tlast, 0);
        tick();
        s0_tdata = 32'h28; s0_tlast = 1; #1;
        check("t1_b2_data", p_s_tdata, 32'h28);
        check("t1_b2_last", p_s_tlast, 1);
        tick();
        s0_tvalid = 0; #1;
        check("t1_back_idle", s0_tready, 0);
        check("t1_busy_fifo", busy, 1);
        p_m_tvalid = 1; p_m_tdata = 32'hAA; p_m_tlast = 1; p_m_tkeep = 4'hF;
        m0_tready = 1; m1_tready = 1; #1;
        check("t1_m0_valid", m0_tvalid, 1);
        check("t1_m0_data", m0_tdata, 32'hAA);
        check("t1_m1_valid", m1_tvalid, 0);
        check("t1_p_m_ready", p_m_tready, 1);
        tick();
        p_m_tvalid = 0; #1;
        check("t1_busy_done", busy, 0);

        // Both requesters valid: alternation until the order FIFO fills
        do_reset();
        s0_tvalid = 1; s1_tvalid = 1; p_s_tready = 1; m0_tready = 1; m1_tready = 1;
        for (int k = 0; k < 4; k++) begin
            x = k % 2;
            s0_tdata = 32'h100 + k*2; s1_tdata = 32'h200 + k*2;
            s0_tlast = 0; s1_tlast = 0; #1;
            check("t2_idle_gap", p_s_tvalid, 0);
            tick();
            for (int b = 0; b < 2; b++) begin
                s0_tdata = 32'h100 + k*2 + b; s1_tdata = 32'h200 + k*2 + b;
                s0_tlast = (b == 1); s1_tlast = (b == 1); #1;
                check("t2_data", p_s_tdata, ((x == 1) ? 32'h200 : 32'h100) + k*2 + b);
                check("t2_last", p_s_tlast, (b == 1));
                check("t2_ready_gnt", (x == 1) ? s1_tready : s0_tready, 1);
                check("t2_ready_oth", (x == 1) ? s0_tready : s1_tready, 0);
                tick();
            end
        end
        s0_tdata = 32'h108; s0_tlast = 1; s1_tlast = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t2_full_valid", p_s_tvalid, 0);
            check("t2_full_s0r", s0_tready, 0);
            check("t2_full_s1r", s1_tready, 0);
            check("t2_full_busy", busy, 1);
            tick();
        end
        p_m_tvalid = 1; p_m_tdata = 32'hC0; p_m_tlast = 1; #1;
        check("t2_r0_m0", m0_tvalid, 1);
        check("t2_r0_m1", m1_tvalid, 0);
        check("t2_r0_data", m0_tdata, 32'hC0);
        tick();
        p_m_tvalid = 0; #1;
        check("t2_post_pop_idle", p_s_tvalid, 0);
        tick();
        check("t2_regrant_valid", p_s_tvalid, 1);
        check("t2_regrant_s0", s0_tready, 1);
        check("t2_regrant_data", p_s_tdata, 32'h108);
        tick();
        s0_tvalid = 0; s1_tvalid = 0;
        for (int i = 0; i < 4; i++) begin
            x = (i % 2 == 0) ? 1 : 0;
            p_m_tvalid = 1; p_m_tdata = 32'hD0 + i; p_m_tlast = 1; #1;
            check("t2_order_valid", (x == 1) ? m1_tvalid : m0_tvalid, 1);
            check("t2_order_other", (x == 1) ? m0_tvalid : m1_tvalid, 0);
            check("t2_order_data", (x == 1) ? m1_tdata : m0_tdata, 32'hD0 + i);
            tick();
        end
        p_m_tvalid = 0; #1;
        check("t2_drained_busy", busy, 0);
        p_m_tvalid = 1; #1;
        check("t2_empty_ready", p_m_tready, 0);
        check("t2_empty_m0", m0_tvalid, 0);
        check("t2_empty_m1", m1_tvalid, 0);
        p_m_tvalid = 0;

        // Backpressure on p_s_tready: handshakes land on cycles 1, 3, 5
        beat = 0; s0_tvalid = 1;
        for (int cyc = 0; cyc < 30 && beat < 3; cyc++) begin
            p_s_tready = (cyc % 2 == 1);
            s0_tdata = 32'h5000 + beat; s0_tlast = (beat == 2); #1;
            if (p_s_tvalid && p_s_tready) begin
                check("t3_data", p_s_tdata, 32'h5000 + beat);
                check("t3_last", p_s_tlast, (beat == 2));
                check("t3_cycle", cyc, 2*beat + 1);
                check("t3_s0_ready", s0_tready, 1);
                beat++;
            end
            tick();
        end
        check("t3_beats", beat, 3);
        s0_tvalid = 0; p_s_tready = 1;
        beat = 0; m1_tready = 1;
        for (int cyc = 0; cyc < 30 && beat < 3; cyc++) begin
            m0_tready = (cyc % 2 == 1);
            p_m_tvalid = 1; p_m_tdata = 32'hE0 + beat; p_m_tlast = (beat == 2); p_m_tkeep = 4'h3; #1;
            check("t3_m1_quiet", m1_tvalid, 0);
            check("t3_p_m_ready", p_m_tready, (cyc % 2 == 1));
            if (m0_tvalid && m0_tready) begin
                check("t3_rsp_data", m0_tdata, 32'hE0 + beat);
                check("t3_rsp_last", m0_tlast, (beat == 2));
                check("t3_rsp_keep", m0_tkeep, 4'h3);
                check("t3_rsp_cycle", cyc, 2*beat + 1);
                beat++;
            end
            tick();
        end
        check("t3_rsp_beats", beat, 3);
        p_m_tvalid = 0; m0_tready = 1; #1;
        check("t3_busy", busy, 0);

        // Reset in the middle of an s1 packet
        s1_tvalid = 1; s1_tdata = 32'h71; s1_tlast = 0; #1;
        tick();
        check("t4_b0_data", p_s_tdata, 32'h71);
        tick();
        s1_tdata = 32'h72; #1;
        check("t4_b1_valid", p_s_tvalid, 1);
        arstn = 0; #1;
        check("t4_rst_valid", p_s_tvalid, 0);
        check("t4_rst_s1r", s1_tready, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_data", p_s_tdata, 0);
        check("t4_rst_last", p_s_tlast, 0);
        s1_tvalid = 0;
        @(negedge clk);
        arstn = 1;
        tick();
        s0_tvalid = 1; s0_tdata = 32'h81; s0_tlast = 1;
        s1_tvalid = 1; s1_tdata = 32'h91; s1_tlast = 1; #1;
        check("t4_idle", p_s_tvalid, 0);
        tick();
        check("t4_ptr0_s0r", s0_tready, 1);
        check("t4_ptr0_s1r", s1_tready, 0);
        check("t4_ptr0_data", p_s_tdata, 32'h81);
        tick();
        s0_tvalid = 0; #1;
        tick();
        check("t4_s1_ready", s1_tready, 1);
        check("t4_s1_data", p_s_tdata, 32'h91);
        tick();
        s1_tvalid = 0;

        // Packet counts and routing over five single-requester packets
        do_reset();
`ifdef ARB_PKT_COUNT_EN
        check("t5_cnt0_rst", pkt_cnt0, 0);
        check("t5_cnt1_rst", pkt_cnt1, 0);
`endif
        one_pkt(0, 32'hA001);
        one_pkt(1, 32'hB001);
        one_pkt(0, 32'hA002);
        one_pkt(1, 32'hB002);
        one_pkt(0, 32'hA003);
`ifdef ARB_PKT_COUNT_EN
        check("t5_cnt0", pkt_cnt0, 3);
        check("t5_cnt1", pkt_cnt1, 2);
`endif
        #1;
        check("t5_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
